op_spike_maxer: RTL and testbench
=================================

# op_spike_maxer

Downstream consumer of the SNN core's output spike vector. It tallies per-neuron output spikes across one image presentation, bounded by `start_core_img` and `done_core_img`, then runs a sequential argmax over the N tallies. It publishes the winning neuron label, its spike count and a Q12 threshold value, closing the loop back into the core's `threshold_maxer` / `valid_maxing` inputs.

## Interface
- `N`, 8: number of output neurons (width of `ops`).
- `LW`, 3: label width; must satisfy 2^LW >= N.
- `CW`, 16: per-neuron spike counter width.
- `W`, 24: width of `threshold_maxer`, signed fixed point.
- `FRAC`, 12: fractional bits of `threshold_maxer` (Q12, 4096 = 1.0).

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `start_core_img`  in  1  pulse; begin a new image tally.
- `ops`  in  N  output spike vector from the core.
- `TU_incre`  in  1  time-unit strobe; `ops` is sampled only when this is high.
- `done_core_img`  in  1  pulse; image presentation finished.
- `label`  out  LW  index of the winning neuron.
- `max_count`  out  CW  spike count of the winner.
- `threshold_maxer`  out  W  `max_count` scaled to Q12, saturated.
- `valid_maxing`  out  1  one-cycle pulse; outputs updated this cycle.
- `tie`  out  1  two or more neurons share the maximum (includes the all-zero case).
- `busy`  out  1  high in TALLY or SCAN.

## Operation
- FSM states: IDLE, TALLY, SCAN, DONE.
- IDLE:
  - `start_core_img` clears all N counters and moves to TALLY.
  - `TU_incre` and `done_core_img` are ignored.
- TALLY:
  - On each `TU_incre`, counter[i] increments for every i with `ops[i]`=1.
  - Counters saturate at 2^CW-1 and never wrap.
  - `done_core_img` moves to SCAN. If `TU_incre` is high in the same cycle, that cycle's spikes are counted first.
- SCAN: one neuron per cycle, index 0..N-1, N cycles total.
  - Keeps running best index, best count and a tie flag.
  - Strictly greater count replaces the best and clears the tie flag.
  - Equal count sets the tie flag; the lower index is retained.
  - After index N-1, move to DONE.
- DONE:
  - Load `label`, `max_count`, `tie` and `threshold_maxer`.
  - Pulse `valid_maxing`.
  - Return to IDLE the next cycle.
- `threshold_maxer` = `max_count` << FRAC, computed at CW+FRAC width. If the result exceeds 2^(W-1)-1, output 2^(W-1)-1.
- All-zero tallies: `label`=0, `max_count`=0, `threshold_maxer`=0, `tie`=1 when N>1.
- `start_core_img` in TALLY, SCAN or DONE aborts the current image:
  - Counters clear and the FSM enters TALLY.
  - No `valid_maxing` pulse is issued.
  - Published outputs keep their previous values.
- `start_core_img` with `TU_incre` in the same cycle: counters clear; that cycle's `ops` is not counted.
- `start_core_img` with `done_core_img` in the same cycle: start wins and the FSM enters TALLY.
- Published outputs change only in DONE and hold until the next DONE.

## Timing
- Reset (`rst`=0): FSM=IDLE, all counters 0. Outputs: `label`=0, `max_count`=0, `threshold_maxer`=0, `valid_maxing`=0, `tie`=0, `busy`=0.
- Reset deassertion mid-image: the block is in IDLE and needs a fresh `start_core_img`.
- `start_core_img` at cycle t: counters read 0 at t+1, `busy`=1 from t+1.
- `TU_incre` at cycle t: the incremented counter is visible at t+1.
- `done_core_img` at cycle d:
  - SCAN runs cycles d+1..d+N.
  - DONE, with the `valid_maxing` pulse and outputs updated, is at cycle d+N+1.
  - `busy` is 0 from d+N+1.
- Latency from done to valid is N+1 cycles.
- `valid_maxing` is exactly one cycle wide. It never asserts without a preceding done in TALLY.

## Test plan
- Reset, start, 10 `TU_incre` with `ops`=8'b0010_0100, done at cycle d:
  - `valid_maxing` at d+9.
  - `label`=2, `max_count`=10, `tie`=1, `threshold_maxer`=40960.
- Unique winner: neuron 5 spikes 7 times, neuron 1 spikes 3 times, others 0:
  - `label`=5, `max_count`=7, `tie`=0, `threshold_maxer`=28672.
- Saturation, CW=16: drive neuron 3 for 70000 `TU_incre`:
  - `max_count`=65535.
  - `threshold_maxer`=8388607 (W-bit saturation).
- No spikes between start and done:
  - `label`=0, `max_count`=0, `tie`=1, `valid_maxing` pulses once.
- Abort: complete one image (label=4), start a new one, issue a second `start_core_img` during SCAN:
  - No `valid_maxing` pulse.
  - `label` stays 4.
  - Counters read 0 the next cycle.
- Same-cycle edge cases:
  - `TU_incre`+`done_core_img` with `ops`=8'h01 after 2 prior hits on neuron 0: `max_count`=3.
  - `start_core_img`+`TU_incre` from TALLY: counters read 0 the next cycle.
  - `rst` pulsed low mid-SCAN: all outputs 0, no valid pulse.

Source files
------------

// File: rtl/op_spike_maxer.sv
// op_spike_maxer: tallies output spikes per neuron over one image, then argmax-scans them into a label and Q12 threshold
`timescale 1ns/1ps
module op_spike_maxer #(
  parameter int N    = 8,
  parameter int LW   = 3,
  parameter int CW   = 16,
  parameter int W    = 24,
  parameter int FRAC = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_core_img,
  input  logic [N-1:0]  ops,
  input  logic          TU_incre,
  input  logic          done_core_img,
  output logic [LW-1:0] label,
  output logic [CW-1:0] max_count,
  output logic [W-1:0]  threshold_maxer,
  output logic          valid_maxing,
  output logic          tie,
  output logic          busy
);
  localparam int XW = (CW + FRAC > W) ? CW + FRAC : W;
  localparam logic [XW-1:0] MAXV = XW'((64'd1 << (W - 1)) - 64'd1);
  typedef enum logic [1:0] {IDLE, TALLY, SCAN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt [N];
  logic [LW-1:0] idx, best_idx, nb_idx;
  logic [CW-1:0] best_cnt, nb_cnt;
  logic best_tie, nb_tie, take;
  logic [XW-1:0] shifted;
  logic [W-1:0] thr;
  // index 0 seeds the running best; later equal counts only raise the tie flag
  assign take     = (idx == '0) || (cnt[idx] > best_cnt);
  assign nb_idx   = take ? idx : best_idx;
  assign nb_cnt   = take ? cnt[idx] : best_cnt;
  assign nb_tie   = take ? 1'b0 : ((cnt[idx] == best_cnt) | best_tie);
  assign shifted  = XW'(nb_cnt) << FRAC;
  assign thr      = (shifted > MAXV) ? MAXV[W-1:0] : shifted[W-1:0];
  assign busy     = (state == TALLY) || (state == SCAN);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      idx             <= '0;
      best_idx        <= '0;
      best_cnt        <= '0;
      best_tie        <= 1'b0;
      label           <= '0;
      max_count       <= '0;
      threshold_maxer <= '0;
      valid_maxing    <= 1'b0;
      tie             <= 1'b0;
    end else begin
      valid_maxing <= 1'b0;
      if (start_core_img) begin
        for (int i = 0; i < N; i++) cnt[i] <= '0;
        idx   <= '0;
        state <= TALLY;
      end else begin
        case (state)
          TALLY: begin
            if (TU_incre)
              for (int i = 0; i < N; i++)
                if (ops[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
            if (done_core_img) begin
              idx   <= '0;
              state <= SCAN;
            end
          end
          SCAN: begin
            best_idx <= nb_idx;
            best_cnt <= nb_cnt;
            best_tie <= nb_tie;
            idx      <= idx + 1'b1;
            if (idx == LW'(N - 1)) begin
              label           <= nb_idx;
              max_count       <= nb_cnt;
              tie             <= nb_tie;
              threshold_maxer <= thr;
              valid_maxing    <= 1'b1;
              state           <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_op_spike_maxer.sv
// tb_op_spike_maxer: scoreboard bench for op_spike_maxer with a saturating per-neuron tally model
`timescale 1ns/1ps
module tb_op_spike_maxer;
  localparam int N = 8, LW = 3, CW = 16, W = 24, FRAC = 12;
  localparam longint CMAX = 65535, TMAX = 8388607;
  logic clk = 1'b0, rst = 1'b0, start_core_img = 1'b0, TU_incre = 1'b0, done_core_img = 1'b0;
  logic [N-1:0] ops = '0;
  logic [LW-1:0] label;
  logic [CW-1:0] max_count;
  logic [W-1:0] threshold_maxer;
  logic valid_maxing, tie, busy;
  typedef struct {longint lbl; longint cnt; bit tie; longint thr; longint at;} exp_t;
  exp_t sb[$];
  exp_t got_e;
  longint mcnt [N];
  bit tallying = 1'b0;
  longint cyc = 0;
  int n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;
  op_spike_maxer #(.N(N), .LW(LW), .CW(CW), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start_core_img(start_core_img), .ops(ops), .TU_incre(TU_incre),
    .done_core_img(done_core_img), .label(label), .max_count(max_count),
    .threshold_maxer(threshold_maxer), .valid_maxing(valid_maxing), .tie(tie), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(longint at);
    exp_t e;
    longint m = -1;
    int same = 0;
    for (int i = 0; i < N; i++) if (mcnt[i] > m) begin m = mcnt[i]; e.lbl = i; end
    for (int i = 0; i < N; i++) if (mcnt[i] == m) same++;
    e.cnt = m;
    e.tie = same > 1;
    e.thr = (m * 4096 > TMAX) ? TMAX : m * 4096;
    e.at  = at;
    return e;
  endfunction
  // one clock of stimulus; the model tracks only what an idle/tallying block would accept
  task automatic cyc1(bit s, bit t, bit d, logic [N-1:0] o);
    start_core_img = s; TU_incre = t; done_core_img = d; ops = o;
    if (s) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      tallying = 1'b1;
    end else if (tallying) begin
      if (t) for (int i = 0; i < N; i++) if (o[i] && mcnt[i] < CMAX) mcnt[i]++;
      if (d) begin
        sb.push_back(mk(cyc + N + 1));
        n_push++;
        tallying = 1'b0;
      end
    end
    @(posedge clk); #1;
    start_core_img = 1'b0; TU_incre = 1'b0; done_core_img = 1'b0; ops = '0;
  endtask
  task automatic tu(logic [N-1:0] o, int n);
    repeat (n) cyc1(1'b0, 1'b1, 1'b0, o);
  endtask
  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  always @(negedge clk) begin
    if (rst && valid_maxing) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        got_e = sb.pop_front();
        n_pop++;
        chk("label", label, got_e.lbl);
        chk("max_count", max_count, got_e.cnt);
        chk("tie", tie, got_e.tie);
        chk("threshold", threshold_maxer, got_e.thr);
        chk("latency", cyc, got_e.at);
        chk("busy_at_done", busy, 0);
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    idle(3);
    chk("rst_label", label, 0);
    chk("rst_max", max_count, 0);
    chk("rst_thr", threshold_maxer, 0);
    chk("rst_valid", valid_maxing, 0);
    chk("rst_tie", tie, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    idle(1);
    // two neurons tie at 10
    cyc1(1'b1, 1'b0, 1'b0, '0);
    chk("busy_start", busy, 1);
    tu(8'b0010_0100, 10);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // unique winner
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'b0010_0010, 3);
    tu(8'b0010_0000, 4);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // done in IDLE is ignored
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // counter and threshold saturation
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'h08, 70000);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // no spikes
    cyc1(1'b1, 1'b0, 1'b0, '0);
    idle(4);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // abort during SCAN after a completed label-4 image
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'h10, 5);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'h12, 3);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(3);
    void'(sb.pop_back());
    n_push--;
    cyc1(1'b1, 1'b0, 1'b0, '0);
    idle(N + 3);
    chk("abort_label", label, 4);
    chk("abort_max", max_count, 5);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // TU with done in the same cycle
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'h01, 2);
    cyc1(1'b0, 1'b1, 1'b1, 8'h01);
    idle(N + 3);
    // start with TU from TALLY: that cycle's spikes are dropped
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'hFF, 4);
    cyc1(1'b1, 1'b1, 1'b0, 8'h80);
    tu(8'h40, 1);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // start with done: start wins
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'h04, 2);
    cyc1(1'b1, 1'b0, 1'b1, '0);
    chk("start_done_busy", busy, 1);
    tu(8'h20, 1);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(N + 3);
    // reset mid-SCAN
    cyc1(1'b1, 1'b0, 1'b0, '0);
    tu(8'h08, 2);
    cyc1(1'b0, 1'b0, 1'b1, '0);
    idle(3);
    void'(sb.pop_back());
    n_push--;
    tallying = 1'b0;
    rst = 1'b0;
    idle(1);
    chk("midrst_label", label, 0);
    chk("midrst_max", max_count, 0);
    chk("midrst_thr", threshold_maxer, 0);
    chk("midrst_tie", tie, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    idle(N + 3);
    chk("midrst_valid", valid_maxing, 0);
    chk("sb_drain", sb.size(), 0);
    chk("valid_count", n_pop, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
